// File: rtl/reset_sequencer_pkg.sv
// ============================================================================
// reset_sequencer_pkg : FSM state and reset-cause encodings for reset_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STAGING   = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POWER = 2'b00,
    CAUSE_KEY   = 2'b01,
    CAUSE_LOCK  = 2'b10,
    CAUSE_SW    = 2'b11
  } cause_e;

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sequencer_sync_debounce.sv
// ============================================================================
// reset_sequencer_sync_debounce : multi-stage synchroniser with optional
// stability filter (DEBOUNCE_CYCLES=0 gives a plain synchroniser)
// Revision: 1.0
// ============================================================================
`default_nettype none

module reset_sequencer_sync_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic din_i,
  output logic dout_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   w_sync;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= din_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign w_sync = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_passthru
      assign dout_o = w_sync;
    end else begin : g_debounce
      localparam int CW = cnt_width(DEBOUNCE_CYCLES);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          deb_q, deb_d;

      // Count consecutive disagreeing cycles; any agreeing cycle restarts it.
      always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (w_sync != deb_q) begin
          if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb_d = w_sync;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          cnt_q <= '0;
          deb_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          deb_q <= deb_d;
        end
      end

      assign dout_o = deb_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// reset_sequencer : merges master, key, PLL-lock and software resets and
// releases NUM_DOMAINS active-low resets in staged order; records last cause
// Revision: 1.0
// ============================================================================
`default_nettype none

module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_DOMAINS        = 3,
  parameter int SYNC_STAGES        = 2,
  parameter int DEBOUNCE_CYCLES    = 4,
  parameter int LOCK_STABLE_CYCLES = 8,
  parameter int STAGE_GAP_CYCLES   = 2,
  parameter int MIN_HOLD_CYCLES    = 3
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   key_resetn,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   ready,
  output logic [1:0]             reset_cause
);

  localparam int HW = cnt_width(MIN_HOLD_CYCLES);
  localparam int LW = cnt_width(LOCK_STABLE_CYCLES);
  localparam int GW = cnt_width(STAGE_GAP_CYCLES);
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  logic w_key_deb;
  logic w_lock_sync;

  reset_sequencer_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clock (clock),
    .resetn(resetn),
    .din_i (key_resetn),
    .dout_o(w_key_deb)
  );

  reset_sequencer_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(0)
  ) u_lock (
    .clock (clock),
    .resetn(resetn),
    .din_i (pll_locked),
    .dout_o(w_lock_sync)
  );

  state_e                 state_q, state_d;
  cause_e                 cause_q, cause_d;
  cause_e                 w_cause;
  logic [HW-1:0]          hold_q, hold_d;
  logic [LW-1:0]          lock_q, lock_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   w_fault_wait;
  logic                   w_fault_act;

  // Lock loss is only a fault once staging has begun.
  assign w_fault_wait = !w_key_deb || sw_reset_req;
  assign w_fault_act  = !w_key_deb || !w_lock_sync || sw_reset_req;
  assign w_cause      = !w_key_deb   ? CAUSE_KEY  :
                        !w_lock_sync ? CAUSE_LOCK : CAUSE_SW;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    hold_d  = hold_q;
    lock_d  = '0;
    gap_d   = gap_q;
    idx_d   = idx_q;
    rst_d   = rst_q;

    unique case (state_q)
      ST_HOLD: begin
        rst_d = '0;
        if (hold_q == HW'(MIN_HOLD_CYCLES)) begin
          if (w_key_deb) state_d = ST_WAIT_LOCK;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        if (w_fault_wait) begin
          state_d = ST_HOLD;
          cause_d = w_key_deb ? CAUSE_SW : CAUSE_KEY;
          hold_d  = '0;
        end else if (w_lock_sync) begin
          if (lock_q == LW'(LOCK_STABLE_CYCLES - 1)) begin
            state_d  = ST_STAGING;
            lock_d   = LW'(LOCK_STABLE_CYCLES);
            idx_d    = '0;
            gap_d    = '0;
            rst_d    = '0;
            rst_d[0] = 1'b1;
          end else begin
            lock_d = lock_q + 1'b1;
          end
        end
      end

      ST_STAGING: begin
        if (w_fault_act) begin
          state_d = ST_HOLD;
          cause_d = w_cause;
          hold_d  = '0;
          gap_d   = '0;
          idx_d   = '0;
          rst_d   = '0;
        end else if (idx_q == IW'(NUM_DOMAINS - 1)) begin
          // Single-domain build: the only bit rose on entry.
          state_d = ST_RUN;
        end else if (gap_q == GW'(STAGE_GAP_CYCLES - 1)) begin
          idx_d        = idx_q + 1'b1;
          gap_d        = '0;
          rst_d[idx_d] = 1'b1;
          if (idx_d == IW'(NUM_DOMAINS - 1)) state_d = ST_RUN;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (w_fault_act) begin
          state_d = ST_HOLD;
          cause_d = w_cause;
          hold_d  = '0;
          gap_d   = '0;
          idx_d   = '0;
          rst_d   = '0;
        end
      end

      default: begin
        state_d = ST_HOLD;
        hold_d  = '0;
        rst_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_HOLD;
      cause_q <= CAUSE_POWER;
      hold_q  <= '0;
      lock_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      hold_q  <= hold_d;
      lock_q  <= lock_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
    end
  end

  assign rst_n_out   = rst_q;
  assign ready       = (state_q == ST_RUN);
  assign reset_cause = cause_q;

endmodule

`default_nettype wire
